// File: rtl/subcarrier_map_ctrl.sv
// subcarrier_map_ctrl: places 48 QPSK data words per OFDM symbol into 64-bin
// IFFT order, inserting nulls and polarity-scrambled pilots, with
// Wishbone-style handshakes toward the mapper (upstream) and the IFFT
// (downstream).
module subcarrier_map_ctrl #(
    parameter logic [6:0]  PILOT_SEED = 7'h7F,
    parameter logic [15:0] P_ONE      = 16'h7FFF
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  bin_idx;
    logic [6:0]  lfsr;

    logic        out_halt;
    logic        wr_req;
    logic        lfsr_out;
    logic        bin_pilot;
    logic        bin_data;
    logic        bin_last;
    logic        emit;
    logic [31:0] gen_word;
    logic [31:0] emit_word;

    // Bin 0 (DC) and the guard band 27..37 carry nothing.
    function automatic logic is_null(input logic [5:0] bin);
        return (bin == 6'd0) || ((bin >= 6'd27) && (bin <= 6'd37));
    endfunction

    function automatic logic is_pilot(input logic [5:0] bin);
        return (bin == 6'd7) || (bin == 6'd21) || (bin == 6'd43) || (bin == 6'd57);
    endfunction

    function automatic logic signed [15:0] negate(input logic signed [15:0] v);
        return -v;
    endfunction

    // Bin 21 has a -1 base value; the symbol polarity flips every pilot.
    function automatic logic [31:0] pilot_value(input logic [5:0] bin,
                                                input logic       neg);
        logic signed [15:0] re;
        if ((bin == 6'd21) ^ neg)
            re = negate($signed(P_ONE));
        else
            re = $signed(P_ONE);
        return {16'h0000, re};
    endfunction

    assign out_halt  = STB_O & ~ACK_I;
    assign wr_req    = CYC_I & STB_I & WE_I;
    assign lfsr_out  = lfsr[6] ^ lfsr[3];
    assign bin_pilot = is_pilot(bin_idx);
    assign bin_data  = ~is_null(bin_idx) & ~bin_pilot;
    assign bin_last  = (bin_idx == 6'd63);
    assign gen_word  = bin_pilot ? pilot_value(bin_idx, lfsr_out) : 32'h0000_0000;

    assign ACK_O = (state == RUN) & bin_data & wr_req & ~out_halt;
    assign WE_O  = STB_O;

    // Decide whether the output register loads this cycle and with what.
    // Data bins while padding resolve to zero through gen_word.
    always_comb begin
        emit      = 1'b0;
        emit_word = gen_word;
        case (state)
            RUN: begin
                if (!out_halt) begin
                    if (!CYC_I) begin
                        // Frame ended mid-symbol: this bin is already padded.
                        emit = (bin_idx != 6'd0);
                    end else if (!bin_data) begin
                        emit = 1'b1;
                    end else if (wr_req) begin
                        emit      = 1'b1;
                        emit_word = DAT_I;
                    end
                end
            end
            PAD:     emit = ~out_halt;
            default: emit = 1'b0;
        endcase
    end

    // Control FSM, bin counter, pilot-polarity LFSR and registered outputs.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= IDLE;
            bin_idx <= 6'd0;
            lfsr    <= PILOT_SEED;
            DAT_O   <= 32'h0000_0000;
            STB_O   <= 1'b0;
            CYC_O   <= 1'b0;
        end else begin
            if (emit) begin
                DAT_O   <= emit_word;
                STB_O   <= 1'b1;
                bin_idx <= bin_idx + 6'd1;
                // Wrap to bin 0 starts a new symbol with the next polarity.
                if (bin_last)
                    lfsr <= {lfsr[5:0], lfsr_out};
            end else if (!out_halt) begin
                // Held word has been taken and nothing new: bubble.
                STB_O <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state   <= RUN;
                        bin_idx <= 6'd0;
                        lfsr    <= PILOT_SEED;
                        CYC_O   <= 1'b1;
                    end else if (!STB_O) begin
                        // Last word already gone; close the downstream frame.
                        CYC_O <= 1'b0;
                    end
                end
                RUN: begin
                    if (!CYC_I) begin
                        if ((bin_idx == 6'd0) || (emit && bin_last))
                            state <= IDLE;
                        else
                            state <= PAD;
                    end
                end
                PAD: begin
                    if (emit && bin_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subcarrier_map_ctrl.sv
// Directed bench for subcarrier_map_ctrl: full frames, downstream stalls,
// upstream gaps, mid-symbol frame end with padding, and async reset.
module tb_subcarrier_map_ctrl;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [31:0] DAT_I = 32'h0;
    logic        CYC_I = 1'b0;
    logic        STB_I = 1'b0;
    logic        WE_I  = 1'b0;
    logic        ACK_I = 1'b1;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;

    int tests = 0;
    int fails = 0;

    logic [31:0] out_q[$];
    int          ack_cnt = 0;

    // Pilot polarity per symbol from seed 7'h7F: + + + + -
    logic [4:0]  pol_neg_mask = 5'b10000;

    subcarrier_map_ctrl #(
        .PILOT_SEED(7'h7F),
        .P_ONE     (16'h7FFF)
    ) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .DAT_I(DAT_I),
        .CYC_I(CYC_I),
        .STB_I(STB_I),
        .WE_I (WE_I),
        .ACK_O(ACK_O),
        .DAT_O(DAT_O),
        .CYC_O(CYC_O),
        .STB_O(STB_O),
        .WE_O (WE_O),
        .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    // Record every downstream transfer and every upstream accept.
    always @(negedge CLK_I) begin
        if (!RST_I && STB_O && ACK_I) out_q.push_back(DAT_O);
        if (!RST_I && ACK_O) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return {16'hA000 + 16'(k), 16'h5000 + 16'(k)};
    endfunction

    function automatic logic [31:0] qget(input int i);
        if (i >= 0 && i < out_q.size()) return out_q[i];
        return 32'hXXXX_XXXX;
    endfunction

    // Feed n words (numbered from base). Optional 1-2 cycle STB_I gaps every
    // 4 words, optional 3-cycle downstream stall after halt_at outputs.
    task automatic stream(input int n, input int base, input bit gaps,
                          input int halt_at, input int maxcyc);
        int sent, cyc, gap, qb0;
        bit acked, halted;
        logic [31:0] h_dat;
        logic        h_stb;
        sent = 0; cyc = 0; gap = 0; halted = 0; qb0 = out_q.size();
        CYC_I = 1'b1;
        WE_I  = 1'b1;
        while (sent < n && cyc < maxcyc) begin
            if (halt_at >= 0 && !halted && (out_q.size() - qb0) >= halt_at) begin
                halted = 1'b1;
                ACK_I  = 1'b0;
                h_dat  = DAT_O;
                h_stb  = STB_O;
                chk("halt_stb_high", STB_O, 32'd1);
                for (int i = 0; i < 3; i++) begin
                    @(posedge CLK_I); #1;
                    chk($sformatf("halt_dat_hold_%0d", i), DAT_O, h_dat);
                    chk($sformatf("halt_stb_hold_%0d", i), STB_O, h_stb);
                    chk($sformatf("halt_we_hold_%0d", i), WE_O, h_stb);
                    chk($sformatf("halt_ack_o_low_%0d", i), ACK_O, 32'd0);
                end
                ACK_I = 1'b1;
            end
            if (gap > 0) begin
                STB_I = 1'b0;
                DAT_I = 32'hDEAD_BEEF;
                gap--;
            end else begin
                STB_I = 1'b1;
                DAT_I = word(base + sent);
            end
            @(negedge CLK_I);
            acked = ACK_O;
            @(posedge CLK_I); #1;
            if (acked) begin
                sent++;
                if (gaps && (sent % 4 == 0)) gap = 1 + (sent / 4) % 2;
            end
            cyc++;
        end
        STB_I = 1'b0;
        chk("stream_words_accepted", sent, n);
    endtask

    // Drop CYC_I, then expect STB_O low and CYC_O low one cycle later.
    task automatic end_frame(input string tag);
        int c;
        c = 0;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        while (STB_O !== 1'b0 && c < 200) begin
            @(negedge CLK_I);
            c++;
        end
        chk({tag, "_stb_low"}, STB_O, 32'd0);
        chk({tag, "_cyc_still_high"}, CYC_O, 32'd1);
        @(negedge CLK_I);
        chk({tag, "_cyc_low"}, CYC_O, 32'd0);
        @(posedge CLK_I); #1;
    endtask

    // Compare the captured outputs against the bin map.
    task automatic check_frame(input string tag, input int qb, input int nsym,
                               input int nwords, input int base);
        int k;
        logic [31:0] e;
        k = 0;
        chk({tag, "_output_count"}, out_q.size() - qb, nsym * 64);
        for (int s = 0; s < nsym; s++) begin
            for (int b = 0; b < 64; b++) begin
                if (b == 0 || (b >= 27 && b <= 37)) begin
                    e = 32'h0;
                end else if (b == 7 || b == 21 || b == 43 || b == 57) begin
                    e = (pol_neg_mask[s] ^ (b == 21)) ? 32'h0000_8001 : 32'h0000_7FFF;
                end else begin
                    e = (k < nwords) ? word(base + k) : 32'h0;
                    k++;
                end
                chk($sformatf("%s_sym%0d_bin%0d", tag, s, b), qget(qb + s * 64 + b), e);
            end
        end
    endtask

    initial begin
        int qb, ab, c;

        // Reset state
        repeat (2) @(posedge CLK_I);
        #1;
        chk("rst_dat_o", DAT_O, 32'h0);
        chk("rst_stb_o", STB_O, 32'd0);
        chk("rst_cyc_o", CYC_O, 32'd0);
        chk("rst_ack_o", ACK_O, 32'd0);
        chk("rst_we_o", WE_O, 32'd0);
        RST_I = 1'b0;
        @(posedge CLK_I); #1;

        // Five full symbols, downstream always ready
        qb = out_q.size(); ab = ack_cnt;
        stream(240, 0, 1'b0, -1, 2000);
        end_frame("a");
        check_frame("a", qb, 5, 240, 0);
        chk("a_ack_pulses", ack_cnt - ab, 240);
        chk("a_bin1_is_d0", qget(qb + 1), word(0));
        chk("a_bin63_is_d47", qget(qb + 63), word(47));
        chk("a_pol_sym0", qget(qb + 0 * 64 + 7), 32'h0000_7FFF);
        chk("a_pol_sym1", qget(qb + 1 * 64 + 7), 32'h0000_7FFF);
        chk("a_pol_sym2", qget(qb + 2 * 64 + 7), 32'h0000_7FFF);
        chk("a_pol_sym3", qget(qb + 3 * 64 + 7), 32'h0000_7FFF);
        chk("a_pol_sym4", qget(qb + 4 * 64 + 7), 32'h0000_8001);

        // Downstream stall of 3 cycles mid-symbol
        qb = out_q.size(); ab = ack_cnt;
        stream(48, 1000, 1'b0, 20, 500);
        end_frame("b");
        check_frame("b", qb, 1, 48, 1000);
        chk("b_ack_pulses", ack_cnt - ab, 48);

        // Upstream strobe gaps of 1-2 cycles every 4 words, two symbols
        qb = out_q.size(); ab = ack_cnt;
        stream(96, 2000, 1'b1, -1, 1000);
        end_frame("c");
        check_frame("c", qb, 2, 96, 2000);
        chk("c_ack_pulses", ack_cnt - ab, 96);

        // Frame ends after 10 data words: rest of the symbol is padded
        qb = out_q.size(); ab = ack_cnt;
        stream(10, 3000, 1'b0, -1, 200);
        end_frame("d");
        check_frame("d", qb, 1, 10, 3000);
        chk("d_ack_pulses", ack_cnt - ab, 10);

        // Asynchronous reset while bin 30 is on the output
        qb = out_q.size();
        stream(24, 4000, 1'b0, -1, 300);
        c = 0;
        while ((out_q.size() - qb) < 30 && c < 100) begin
            @(posedge CLK_I); #1;
            c++;
        end
        chk("e_reached_bin30", out_q.size() - qb, 30);
        chk("e_stb_before_rst", STB_O, 32'd1);
        chk("e_cyc_before_rst", CYC_O, 32'd1);
        RST_I = 1'b1;
        #1;
        chk("e_rst_dat_o", DAT_O, 32'h0);
        chk("e_rst_stb_o", STB_O, 32'd0);
        chk("e_rst_cyc_o", CYC_O, 32'd0);
        chk("e_rst_ack_o", ACK_O, 32'd0);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        @(posedge CLK_I); #1;
        chk("e_idle_cyc_o", CYC_O, 32'd0);
        qb = out_q.size(); ab = ack_cnt;
        stream(48, 5000, 1'b0, -1, 500);
        end_frame("e");
        check_frame("e", qb, 1, 48, 5000);
        chk("e_bin0_null", qget(qb), 32'h0);
        chk("e_bin7_pos", qget(qb + 7), 32'h0000_7FFF);
        chk("e_ack_pulses", ack_cnt - ab, 48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
